// File: rtl/battery_pkg.sv
// Shared types and constants for the two-cell battery source model.
// Cell width default, level ceiling derivation and FSM state encoding.
package battery_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_A    = 2'd0,
        ST_B    = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    function automatic int unsigned max_level(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/battery_source_if.sv
// Control and level bus between the battery source and its driver.
// master drives the controls and reads levels; slave is the source side.
interface battery_source_if #(
    parameter int unsigned WIDTH = battery_pkg::WIDTH_DEFAULT
);
    logic             tick;
    logic             load_req;
    logic             charge_en;
    logic             preset;
    logic [WIDTH-1:0] init_a;
    logic [WIDTH-1:0] init_b;
    logic [WIDTH-1:0] batt_a;
    logic [WIDTH-1:0] batt_b;
    logic             src_sel;
    logic             load_ok;
    logic             chg_a;
    logic             chg_b;

    modport master (
        output tick, load_req, charge_en, preset, init_a, init_b,
        input  batt_a, batt_b, src_sel, load_ok, chg_a, chg_b
    );

    modport slave (
        input  tick, load_req, charge_en, preset, init_a, init_b,
        output batt_a, batt_b, src_sel, load_ok, chg_a, chg_b
    );
endinterface

// File: rtl/battery_cell.sv
// One cell level register with load, increment and decrement, saturating at 0 and MAX.
// The next level is exported so the owner can make decisions on it in the same cycle.
module battery_cell
    import battery_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned RST_LEVEL = max_level(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] level_nxt_o
);
    localparam logic [WIDTH-1:0] MAX   = WIDTH'(max_level(WIDTH));
    localparam logic [WIDTH-1:0] RST_L = WIDTH'(RST_LEVEL);

    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;

    always_comb begin
        level_d = level_q;
        if (load_i) begin
            level_d = load_val_i;
        end else if (inc_i && !dec_i && level_q != MAX) begin
            level_d = level_q + 1'b1;
        end else if (dec_i && !inc_i && level_q != '0) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= RST_L;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o     = level_q;
    assign level_nxt_o = level_d;

endmodule

// File: rtl/battery_source.sv
// Two-cell battery source: discharges the active cell into the load and charges
// one cell per tick, swapping the active cell or going dead as levels run out.
module battery_source
    import battery_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned RST_LEVEL = max_level(WIDTH)
) (
    input logic             clk,
    input logic             rst,
    battery_source_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX       = WIDTH'(max_level(WIDTH));
    localparam state_e           RST_STATE = (RST_LEVEL == 0) ? ST_DEAD : ST_A;

    state_e           state_q, state_d;
    logic             src_sel_q, src_sel_d;
    logic             load_ok_q, load_ok_d;
    logic             chg_a_q, chg_a_d;
    logic             chg_b_q, chg_b_d;
    logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt;
    logic             step, discharge, dec_a, dec_b, inc_a, inc_b, tgt_b;

    battery_cell #(.WIDTH(WIDTH), .RST_LEVEL(RST_LEVEL)) u_cell_a (
        .clk(clk), .rst(rst), .load_i(bus.preset), .load_val_i(bus.init_a),
        .inc_i(inc_a), .dec_i(dec_a), .level_o(a_q), .level_nxt_o(a_nxt)
    );

    battery_cell #(.WIDTH(WIDTH), .RST_LEVEL(RST_LEVEL)) u_cell_b (
        .clk(clk), .rst(rst), .load_i(bus.preset), .load_val_i(bus.init_b),
        .inc_i(inc_b), .dec_i(dec_b), .level_o(b_q), .level_nxt_o(b_nxt)
    );

    always_comb begin
        step      = bus.tick && !bus.preset;
        discharge = step && bus.load_req && (state_q != ST_DEAD);
        dec_a     = discharge && (state_q == ST_A);
        dec_b     = discharge && (state_q == ST_B);
        // A discharging cell is never eligible; otherwise the lower cell wins, ties to A.
        tgt_b     = dec_a ? 1'b1 : (dec_b ? 1'b0 : (b_q < a_q));
        inc_a     = step && bus.charge_en && !tgt_b && (a_q != MAX);
        inc_b     = step && bus.charge_en &&  tgt_b && (b_q != MAX);

        state_d = state_q;
        if (bus.preset || (step && state_q == ST_DEAD)) begin
            if (a_nxt != '0) begin
                state_d = ST_A;
            end else if (b_nxt != '0) begin
                state_d = ST_B;
            end else begin
                state_d = ST_DEAD;
            end
        end else if (step && state_q == ST_A && a_nxt == '0) begin
            state_d = (b_nxt != '0) ? ST_B : ST_DEAD;
        end else if (step && state_q == ST_B && b_nxt == '0) begin
            state_d = (a_nxt != '0) ? ST_A : ST_DEAD;
        end

        src_sel_d = src_sel_q;
        if (state_d == ST_A) begin
            src_sel_d = 1'b0;
        end else if (state_d == ST_B) begin
            src_sel_d = 1'b1;
        end
        load_ok_d = (state_d != ST_DEAD);
        chg_a_d   = inc_a;
        chg_b_d   = inc_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_STATE;
            src_sel_q <= 1'b0;
            load_ok_q <= (RST_STATE != ST_DEAD);
            chg_a_q   <= 1'b0;
            chg_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_sel_q <= src_sel_d;
            load_ok_q <= load_ok_d;
            chg_a_q   <= chg_a_d;
            chg_b_q   <= chg_b_d;
        end
    end

    assign bus.batt_a  = a_q;
    assign bus.batt_b  = b_q;
    assign bus.src_sel = src_sel_q;
    assign bus.load_ok = load_ok_q;
    assign bus.chg_a   = chg_a_q;
    assign bus.chg_b   = chg_b_q;

endmodule

// File: tb/tb_battery_source.sv
// Bench for battery_source: directed vector table followed by random
// stimulus checked against a cell-array reference model.
module tb_battery_source;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    battery_source_if #(.WIDTH(4)) bus ();

    battery_source #(.WIDTH(4), .RST_LEVEL(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string name;
        bit    r, p, t, ld, ce;
        int    ia, ib;
        int    ea, eb, esel, eok, eca, ecb;
    } vec_t;

    vec_t vecs[$];

    // Reference state: cell levels indexed 0=A, 1=B, the serving cell and a dead flag.
    int lvl[2];
    int m_sel, m_dead, m_ca, m_cb;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input int ea, input int eb,
                             input int esel, input int eok, input int eca, input int ecb);
        check({name, ".batt_a"},  int'(bus.batt_a),  ea);
        check({name, ".batt_b"},  int'(bus.batt_b),  eb);
        check({name, ".src_sel"}, int'(bus.src_sel), esel);
        check({name, ".load_ok"}, int'(bus.load_ok), eok);
        check({name, ".chg_a"},   int'(bus.chg_a),   eca);
        check({name, ".chg_b"},   int'(bus.chg_b),   ecb);
    endtask

    task automatic drive(input bit r, input bit p, input bit t, input bit ld, input bit ce,
                         input int ia, input int ib);
        rst           = r;
        bus.preset    = p;
        bus.tick      = t;
        bus.load_req  = ld;
        bus.charge_en = ce;
        bus.init_a    = 4'(ia);
        bus.init_b    = 4'(ib);
    endtask

    function automatic vec_t mk(input string name, input bit r, input bit p, input bit t,
                                input bit ld, input bit ce, input int ia, input int ib,
                                input int ea, input int eb, input int esel, input int eok,
                                input int eca, input int ecb);
        vec_t v;
        v.name = name; v.r = r; v.p = p; v.t = t; v.ld = ld; v.ce = ce;
        v.ia = ia; v.ib = ib; v.ea = ea; v.eb = eb; v.esel = esel; v.eok = eok;
        v.eca = eca; v.ecb = ecb;
        return v;
    endfunction

    task automatic model_step(input bit r, input bit p, input bit t, input bit ld,
                              input bit ce, input int ia, input int ib);
        bit dis;
        int tgt;
        m_ca = 0;
        m_cb = 0;
        if (r) begin
            lvl[0] = 15; lvl[1] = 15; m_sel = 0; m_dead = 0;
        end else if (p) begin
            lvl[0] = ia; lvl[1] = ib;
            m_dead = (ia == 0 && ib == 0);
            if (!m_dead) m_sel = (ia == 0) ? 1 : 0;
        end else if (t) begin
            dis = ld && !m_dead;
            if (dis) lvl[m_sel] = lvl[m_sel] - 1;
            if (ce) begin
                if (dis) tgt = 1 - m_sel;
                else     tgt = (lvl[1] < lvl[0]) ? 1 : 0;
                if (lvl[tgt] < 15) begin
                    lvl[tgt] = lvl[tgt] + 1;
                    if (tgt == 0) m_ca = 1; else m_cb = 1;
                end
            end
            if (m_dead) begin
                if (lvl[0] > 0)      begin m_sel = 0; m_dead = 0; end
                else if (lvl[1] > 0) begin m_sel = 1; m_dead = 0; end
            end else if (lvl[m_sel] == 0) begin
                if (lvl[1 - m_sel] > 0) m_sel = 1 - m_sel;
                else                    m_dead = 1;
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        //                name        r  p  t ld ce ia ib   ea eb sel ok ca cb
        vecs.push_back(mk("reset0",   1, 0, 0, 0, 0, 0, 0,  15,15, 0, 1, 0, 0));
        vecs.push_back(mk("reset1",   1, 0, 0, 0, 0, 0, 0,  15,15, 0, 1, 0, 0));
        vecs.push_back(mk("dis_pre",  0, 1, 0, 0, 0, 2, 3,   2, 3, 0, 1, 0, 0));
        vecs.push_back(mk("dis_t1",   0, 0, 1, 1, 0, 0, 0,   1, 3, 0, 1, 0, 0));
        vecs.push_back(mk("dis_swap", 0, 0, 1, 1, 0, 0, 0,   0, 3, 1, 1, 0, 0));
        vecs.push_back(mk("dis_t3",   0, 0, 1, 1, 0, 0, 0,   0, 2, 1, 1, 0, 0));
        vecs.push_back(mk("dis_t4",   0, 0, 1, 1, 0, 0, 0,   0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("dis_dead", 0, 0, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("dis_more", 0, 0, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("arb_pre",  0, 1, 0, 0, 0, 5, 3,   5, 3, 0, 1, 0, 0));
        vecs.push_back(mk("arb_t1",   0, 0, 1, 0, 1, 0, 0,   5, 4, 0, 1, 0, 1));
        vecs.push_back(mk("arb_t2",   0, 0, 1, 0, 1, 0, 0,   5, 5, 0, 1, 0, 1));
        vecs.push_back(mk("arb_tie",  0, 0, 1, 0, 1, 0, 0,   6, 5, 0, 1, 1, 0));
        vecs.push_back(mk("idle",     0, 0, 0, 1, 1, 0, 0,   6, 5, 0, 1, 0, 0));
        vecs.push_back(mk("cc_pre",   0, 1, 0, 0, 0, 7, 0,   7, 0, 0, 1, 0, 0));
        vecs.push_back(mk("cc_t1",    0, 0, 1, 1, 1, 0, 0,   6, 1, 0, 1, 0, 1));
        vecs.push_back(mk("sat_pre",  0, 1, 0, 0, 0,15,15,  15,15, 0, 1, 0, 0));
        vecs.push_back(mk("sat_t1",   0, 0, 1, 0, 1, 0, 0,  15,15, 0, 1, 0, 0));
        vecs.push_back(mk("rev_pre",  0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rev_t1",   0, 0, 1, 0, 1, 0, 0,   1, 0, 0, 1, 1, 0));
        vecs.push_back(mk("b_pre",    0, 1, 0, 0, 0, 0, 2,   0, 2, 1, 1, 0, 0));
        vecs.push_back(mk("b_t1",     0, 0, 1, 1, 1, 0, 0,   1, 1, 1, 1, 1, 0));
        vecs.push_back(mk("pri_pt",   0, 1, 1, 1, 1, 4, 4,   4, 4, 0, 1, 0, 0));
        vecs.push_back(mk("pri_rp",   1, 1, 1, 1, 1, 1, 1,  15,15, 0, 1, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].p, vecs[i].t, vecs[i].ld, vecs[i].ce,
                  vecs[i].ia, vecs[i].ib);
            @(posedge clk);
            #1;
            check_all(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].esel,
                      vecs[i].eok, vecs[i].eca, vecs[i].ecb);
        end

        // Random phase: start from a reset so the model and DUT agree.
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("rnd_reset", lvl[0], lvl[1], m_sel, !m_dead, m_ca, m_cb);

        for (int c = 0; c < 3000; c++) begin
            bit r, p, t, ld, ce;
            int ia, ib;
            r  = ($urandom_range(0, 199) == 0);
            p  = ($urandom_range(0, 19) == 0);
            t  = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 3) != 0);
            ce = ($urandom_range(0, 2) == 0);
            ia = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            ib = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            drive(r, p, t, ld, ce, ia, ib);
            model_step(r, p, t, ld, ce, ia, ib);
            @(posedge clk);
            #1;
            check_all("rnd", lvl[0], lvl[1], m_sel, !m_dead, m_ca, m_cb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/battery_source.md
# battery_source

Sequential source model for the two-cell battery bank. It holds the charge level of cells A and B and discharges the active cell into the load on each rate tick. It charges one cell per tick from an external supply and swaps or declares the bank dead when levels run out. Its level outputs drive the level inputs of `battery_bench`, which decodes empty/full status from them.

## Interface
- `WIDTH`, 4, bit width of each cell level; level range is 0 to 2^WIDTH-1 (`MAX`).
- `RST_LEVEL`, 2^WIDTH-1, level both cells take on reset.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: rate strobe; at most one charge step and one discharge step per tick.
- `load_req` in 1: load draws current.
- `charge_en` in 1: external supply present.
- `preset` in 1: load `init_a`/`init_b` into the cells.
- `init_a`, `init_b` in WIDTH: preset levels.
- `batt_a`, `batt_b` out WIDTH: registered cell levels; these feed `battery_bench`.
- `src_sel` out 1: cell supplying the load; 0 = A, 1 = B.
- `load_ok` out 1: registered; 1 when state is not DEAD.
- `chg_a`, `chg_b` out 1: one-cycle pulse marking which cell was charged on the last tick.

## Operation
- Priority of events: `rst` > `preset` > `tick`. With `tick`=0 and no `rst` or `preset`, all registers hold and the charge pulses are 0.
- FSM states:
  - ST_A: A supplies the load.
  - ST_B: B supplies the load.
  - ST_DEAD: both cells empty, no supply.
- Discharge: on `tick` && `load_req` && state != ST_DEAD, the active cell decrements by 1. By invariant the active cell is nonzero, so no underflow occurs.
- Charge: on `tick` && `charge_en`, exactly one cell increments by 1, saturating at MAX.
- Charge target selection:
  - Eligible cells: the non-active cell if a discharge happens this tick, otherwise both cells.
  - Among eligible cells, pick the lower level; ties go to A.
  - If the chosen cell is already at MAX, no increment and no pulse.
- Both the discharge and the charge step are applied to the current levels to form the next levels. State is then computed from the next levels:
  - ST_A: if next A == 0, go to ST_B when next B > 0, else ST_DEAD. Otherwise stay.
  - ST_B: mirror of ST_A.
  - ST_DEAD: go to ST_A if next A > 0, else ST_B if next B > 0, else stay.
- Preset: levels are set to `init_a`/`init_b`. State is set to ST_A if A > 0, else ST_B if B > 0, else ST_DEAD. Charge pulses are 0.
- `src_sel` = 1 only in ST_B. In ST_DEAD, `src_sel` holds its last value.

## Timing
- Reset values:
  - `batt_a` = `batt_b` = RST_LEVEL.
  - State = ST_A (ST_DEAD if RST_LEVEL = 0).
  - `src_sel` = 0.
  - `load_ok` = 1 (0 if RST_LEVEL = 0).
  - `chg_a` = `chg_b` = 0.
- Latency: inputs are sampled at edge N. Levels, state, `src_sel`, `load_ok` and the charge pulses are all valid after edge N. Every output is a register; there is no combinational path from input to output.
- Swap latency is zero extra cycles: the tick that empties the active cell also changes `src_sel` at the same edge.
- Simultaneous discharge and charge are allowed only on different cells. The active cell is never charged while it is discharging.
- `rst` or `preset` asserted mid-sequence overrides a coincident `tick`; that tick is lost.
- Back-to-back ticks (`tick` high every cycle) are legal.

## Structure
- `battery_pkg` holds:
  - The state typedef/localparams: ST_A = 2'd0, ST_B = 2'd1, ST_DEAD = 2'd2.
  - The `WIDTH` default.
  - The `MAX` derivation.
- Sub-module `battery_cell`, instantiated twice: a WIDTH-bit register with `inc`, `dec` and `load` inputs, saturating at 0 and MAX.
- The top module contains the FSM, the charge-target arbitration and the output registers.

## Test plan
All scenarios use WIDTH = 4.
1. Reset: assert `rst` for 2 cycles → `batt_a` = `batt_b` = 15, `src_sel` = 0, `load_ok` = 1, `chg_a` = `chg_b` = 0.
2. Discharge and swap: preset A = 2, B = 3; `load_req` = 1, `charge_en` = 0; 2 ticks → A = 0 and `src_sel` = 1 after the 2nd tick. 3 more ticks → B = 0 and `load_ok` = 0. A further tick leaves both cells at 0.
3. Charge arbitration with no load: preset A = 5, B = 3; `charge_en` = 1; 3 ticks → B reaches 4, then A = 5 is charged on the tie-break? No: levels go B 3→4, B 4→5, then the tie at 5/5 charges A → A = 6, B = 5. `chg_b`, `chg_b`, `chg_a` pulse in that order.
4. Concurrent discharge and charge: preset A = 7, B = 0; `load_req` = 1, `charge_en` = 1; 1 tick → A = 6, B = 1, `chg_b` pulses, `src_sel` = 0.
5. Saturation and revival:
   - Preset A = 15, B = 15, no load, `charge_en` = 1; 1 tick → levels unchanged, no pulse.
   - Preset A = 0, B = 0 → `load_ok` = 0. Then 1 tick with `charge_en` = 1 → A = 1, `load_ok` = 1, `src_sel` = 0.
6. Priority: assert `preset` (A = 4, B = 4) and `tick` in the same cycle → A = B = 4 with no step applied. Assert `rst` together with `preset` → both cells = 15.
